led_chase_sequencer: RTL and testbench
======================================

// Module: led_chase_sequencer
// PURPOSE
//   Time-sequences the 3-to-8 LED decoder/breathing-LED path: steps the decoder channel select
//   (sel -> decoder sw) at a programmable rate and drives the decoder enable code (dec_en -> S).
//   Supports chase-up, chase-down, ping-pong and single-sweep patterns with start/stop/pause
//   control. Sits between board buttons/switches and the decoder; the LED datapath is unchanged.
// PARAMETERS
//   STEP_CNT  2000000  clk cycles per channel step (legal range >= 2)
//   PRE_W     26       prescaler width; must hold STEP_CNT*16-1
// PORTS
//   clk      in   1  system clock, all state on rising edge
//   rst      in   1  asynchronous, active-low reset
//   start    in   1  level; sampled in IDLE, launches a pattern
//   stop     in   1  level; aborts the pattern, highest priority
//   pause    in   1  level; freezes the pattern while high
//   mode     in   2  00 chase up, 01 chase down, 10 ping-pong, 11 single sweep up
//   sel      out  3  channel select to decoder sw
//   dec_en   out  3  decoder enable code: 3'b111 active, 3'b000 blanked
//   busy     out  1  high in RUN and PAUSE
//   step     out  1  1-cycle pulse, first cycle a new sel value is shown
//   done     out  1  1-cycle pulse on single-sweep completion
// BEHAVIOUR
//   - All outputs registered. rst low -> state IDLE, sel=0, dec_en=000, busy=0, step=0, done=0,
//     prescaler=0, dir=up, mode_q=00; takes effect immediately, also mid-pattern.
//   - States IDLE, RUN, PAUSE. Priority per cycle: stop > pause > terminal count.
//   - IDLE: start=1 & stop=0 -> RUN next edge; mode_q<=mode; sel<=7 if mode=01 else 0;
//     dir<=down if mode=01 else up; prescaler<=0; dec_en<=111; busy<=1. No step pulse on launch.
//     start & stop same cycle -> stay IDLE.
//   - RUN: prescaler counts 0..STEP_CNT-1. At edge with prescaler==STEP_CNT-1: prescaler<=0,
//     sel<=next(sel), step<=1 for one cycle. Each channel therefore visible exactly STEP_CNT cycles.
//   - next(): 00 sel+1 mod 8 (7->0); 01 sel-1 mod 8 (0->7); 10 ping-pong, dir flips at
//     endpoints, endpoints shown once per turn (..6,7,6..1,0,1..); 11 sel+1, and at terminal
//     count with sel==7 -> IDLE: sel<=0, dec_en<=000, busy<=0, done<=1 one cycle, no step pulse.
//   - mode is latched at launch; mode changes while busy are ignored. start while busy ignored.
//   - RUN & pause=1 -> PAUSE; prescaler and sel frozen, dec_en stays 111, busy stays 1.
//     Pause beats a coincident terminal count (no advance that cycle). PAUSE & pause=0 -> RUN,
//     prescaler resumes from its frozen value (total dwell = STEP_CNT + paused cycles).
//   - stop=1 in RUN or PAUSE -> IDLE next edge: sel<=0, dec_en<=000, busy<=0, prescaler<=0,
//     no done and no step pulse, even if terminal count coincides.
//   - Prescaler compare is unsigned, PRE_W bits; no wrap other than terminal-count reload.
// CONFIGURATION
//   LED_SEQ_DWELL_EN defined: adds input dwell [3:0]; step period = STEP_CNT*(dwell+1) cycles,
//     dwell sampled at launch and at every step boundary (applies to the next channel).
//   LED_SEQ_DWELL_EN undefined: no dwell port; step period fixed at STEP_CNT cycles.
// TESTING (STEP_CNT=4 unless noted)
//   1 rst low mid-RUN at sel=5 -> same cycle sel=0, dec_en=000, busy=0, step=0, done=0.
//   2 mode=00, start 1 cycle -> sel 0,1..7,0 each held 4 cycles; step every 4th cycle; dec_en=111.
//   3 mode=10 -> sel 0,1,..,7,6,..,0,1 each held 4 cycles; 7 and 0 never repeated back-to-back.
//   4 mode=11 -> 32 cycles after launch: done=1 one cycle, sel=0, dec_en=000, busy=0; no 9th step.
//   5 pause 3 cycles when prescaler=2 at sel=1 -> next step 3 cycles late; stop+start same
//     cycle in IDLE -> stays IDLE; stop at terminal count -> IDLE, no step/done.
//   6 LED_SEQ_DWELL_EN, dwell=2 at launch -> first channel held 12 cycles; dwell=0 written
//     mid-channel -> current channel still 12, following channels 4.

Source files
------------

// File: rtl/led_chase_sequencer.sv
// Steps the 3-to-8 decoder channel select at a programmable rate in chase/ping-pong/sweep patterns.
// Optional build macro LED_SEQ_DWELL_EN adds a per-step dwell multiplier input.
module led_chase_sequencer #(
    parameter int STEP_CNT = 2000000,
    parameter int PRE_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
`ifdef LED_SEQ_DWELL_EN
    input  logic [3:0] dwell,
`endif
    output logic [2:0] sel,
    output logic [2:0] dec_en,
    output logic       busy,
    output logic       step,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_SWEEP = 2'b11;

    localparam logic [PRE_W-1:0] TERM = PRE_W'(STEP_CNT - 1);

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [2:0]       sel_d, dec_en_d;
    logic             busy_d, step_d, done_d;
    logic [3:0]       adv;

`ifdef LED_SEQ_DWELL_EN
    logic [PRE_W-1:0] term_q, term_d;

    function automatic logic [PRE_W-1:0] term_for(input logic [3:0] d);
        term_for = PRE_W'(STEP_CNT * (int'(d) + 1) - 1);
    endfunction
`else
    logic [PRE_W-1:0] term_q;
    assign term_q = TERM;
`endif

    // Returns {dir, sel} for the channel after s; dir=1 means counting down.
    function automatic logic [3:0] advance(input logic [1:0] m, input logic [2:0] s,
                                           input logic d);
        advance = {d, s + 3'd1};
        case (m)
            MODE_DOWN: advance = {d, s - 3'd1};
            MODE_PING: begin
                if (!d)
                    advance = (s == 3'd7) ? {1'b1, 3'd6} : {1'b0, s + 3'd1};
                else
                    advance = (s == 3'd0) ? {1'b0, 3'd1} : {1'b1, s - 3'd1};
            end
            default: advance = {d, s + 3'd1};
        endcase
    endfunction

    assign adv = advance(mode_q, sel, dir_q);

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        sel_d    = sel;
        dec_en_d = dec_en;
        busy_d   = busy;
        step_d   = 1'b0;
        done_d   = 1'b0;
`ifdef LED_SEQ_DWELL_EN
        term_d   = term_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    mode_d   = mode;
                    sel_d    = (mode == MODE_DOWN) ? 3'd7 : 3'd0;
                    dir_d    = (mode == MODE_DOWN);
                    pre_d    = '0;
                    dec_en_d = 3'b111;
                    busy_d   = 1'b1;
`ifdef LED_SEQ_DWELL_EN
                    term_d   = term_for(dwell);
`endif
                end
            end
            RUN, PAUSE: begin
                // Priority: stop, then pause, then terminal count.
                if (stop) begin
                    state_d  = IDLE;
                    sel_d    = 3'd0;
                    dec_en_d = 3'b000;
                    busy_d   = 1'b0;
                    pre_d    = '0;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    state_d = RUN;
                    if (pre_q == term_q) begin
                        pre_d = '0;
                        if (mode_q == MODE_SWEEP && sel == 3'd7) begin
                            state_d  = IDLE;
                            sel_d    = 3'd0;
                            dec_en_d = 3'b000;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                        end else begin
                            {dir_d, sel_d} = adv;
                            step_d         = 1'b1;
`ifdef LED_SEQ_DWELL_EN
                            term_d         = term_for(dwell);
`endif
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                sel_d    = 3'd0;
                dec_en_d = 3'b000;
                busy_d   = 1'b0;
                pre_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pre_q   <= '0;
            mode_q  <= MODE_UP;
            dir_q   <= 1'b0;
            sel     <= 3'd0;
            dec_en  <= 3'b000;
            busy    <= 1'b0;
            step    <= 1'b0;
            done    <= 1'b0;
`ifdef LED_SEQ_DWELL_EN
            term_q  <= TERM;
`endif
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            sel     <= sel_d;
            dec_en  <= dec_en_d;
            busy    <= busy_d;
            step    <= step_d;
            done    <= done_d;
`ifdef LED_SEQ_DWELL_EN
            term_q  <= term_d;
`endif
        end
    end

endmodule

// File: tb/tb_led_chase_sequencer.sv
// Directed bench for led_chase_sequencer: pattern-level reference model plus literal spot checks.
module tb_led_chase_sequencer;

    localparam int STEP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] dwell = 4'd0;
    logic [2:0] sel, dec_en;
    logic       busy, step, done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    led_chase_sequencer #(.STEP_CNT(STEP), .PRE_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
`ifdef LED_SEQ_DWELL_EN
        .dwell  (dwell),
`endif
        .sel    (sel),
        .dec_en (dec_en),
        .busy   (busy),
        .step   (step),
        .done   (done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Pattern model: k is the index of the channel within the pattern, cnt the cycles spent on it.
    int m_busy = 0, m_mode = 0, m_k = 0, m_cnt = 0, m_period = STEP;
    int m_step = 0, m_done = 0;

    function automatic int pat_sel(input int md, input int k);
        int p;
        case (md)
            0: pat_sel = k % 8;
            1: pat_sel = 7 - (k % 8);
            2: begin
                p = k % 14;
                pat_sel = (p <= 7) ? p : 14 - p;
            end
            default: pat_sel = k;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_step = 0; m_done = 0; m_cnt = 0; m_k = 0; m_mode = 0;
        end else begin
            m_step = 0;
            m_done = 0;
            if (m_busy == 0) begin
                if (start && !stop) begin
                    m_busy = 1; m_mode = int'(mode); m_k = 0; m_cnt = 0;
                    m_period = STEP * (int'(dwell) + 1);
                end
            end else if (stop) begin
                m_busy = 0;
            end else if (!pause) begin
                if (m_cnt == m_period - 1) begin
                    m_cnt = 0;
                    if (m_mode == 3 && m_k == 7) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_k++; m_step = 1;
                        m_period = STEP * (int'(dwell) + 1);
                    end
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_sel",    int'(sel),    m_busy ? pat_sel(m_mode, m_k) : 0);
        chk("model_dec_en", int'(dec_en), m_busy ? 7 : 0);
        chk("model_busy",   int'(busy),   m_busy);
        chk("model_step",   int'(step),   m_step);
        chk("model_done",   int'(done),   m_done);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic launch(input logic [1:0] md);
        mode  = md;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        int pp[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

        ticks(2);
        chk("reset_sel", int'(sel), 0);
        chk("reset_dec_en", int'(dec_en), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_step_done", int'({step, done}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // chase up: each channel held STEP cycles, wraps 7 -> 0
        launch(2'b00);
        for (int i = 0; i < 36; i++) begin
            chk("up_sel", int'(sel), (i / 4) % 8);
            chk("up_step", int'(step), (i > 0 && i % 4 == 0) ? 1 : 0);
            chk("up_dec_en", int'(dec_en), 7);
            tick();
        end
        abort();
        chk("up_stop_busy", int'(busy), 0);

        // chase down: launches at 7
        launch(2'b01);
        chk("down_first", int'(sel), 7);
        chk("down_launch_nostep", int'(step), 0);
        ticks(4);
        chk("down_second", int'(sel), 6);
        ticks(28);
        chk("down_wrap", int'(sel), 7);
        abort();

        // ping-pong, with ignored mode change and start while busy
        launch(2'b10);
        for (int j = 0; j < 16; j++) begin
            if (j == 2) begin
                mode  = 2'b00;
                start = 1'b1;
            end
            if (j == 3) start = 1'b0;
            chk("pp_sel", int'(sel), pp[j]);
            ticks(4);
        end
        abort();

        // single sweep
        launch(2'b11);
        ticks(28);
        chk("sweep_last_sel", int'(sel), 7);
        chk("sweep_last_step", int'(step), 1);
        ticks(3);
        chk("sweep_busy_before_done", int'(busy), 1);
        tick();
        chk("sweep_done", int'(done), 1);
        chk("sweep_end_sel", int'(sel), 0);
        chk("sweep_end_dec_en", int'(dec_en), 0);
        chk("sweep_end_busy", int'(busy), 0);
        chk("sweep_no_9th_step", int'(step), 0);
        tick();
        chk("sweep_done_1cyc", int'(done), 0);
        ticks(8);
        chk("sweep_idle_sel", int'(sel), 0);

        // pause for 3 cycles at sel=1, prescaler=2
        launch(2'b00);
        ticks(6);
        pause = 1'b1;
        ticks(3);
        pause = 1'b0;
        chk("pause_dec_en", int'(dec_en), 7);
        chk("pause_busy", int'(busy), 1);
        tick();
        chk("pause_hold_sel", int'(sel), 1);
        chk("pause_hold_step", int'(step), 0);
        tick();
        chk("pause_late_sel", int'(sel), 2);
        chk("pause_late_step", int'(step), 1);
        // stop coincident with terminal count
        ticks(3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_tc_busy", int'(busy), 0);
        chk("stop_tc_sel", int'(sel), 0);
        chk("stop_tc_step_done", int'({step, done}), 0);
        // start and stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_idle", int'(busy), 0);
        tick();

        // asynchronous reset mid-run at sel=5
        launch(2'b00);
        ticks(20);
        chk("rst_pre_sel", int'(sel), 5);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_sel", int'(sel), 0);
        chk("rst_async_dec_en", int'(dec_en), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_step_done", int'({step, done}), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

`ifdef LED_SEQ_DWELL_EN
        dwell = 4'd2;
        launch(2'b00);
        ticks(5);
        dwell = 4'd0;
        ticks(6);
        chk("dwell_first_held", int'(sel), 0);
        tick();
        chk("dwell_first_end", int'(sel), 1);
        chk("dwell_first_step", int'(step), 1);
        ticks(3);
        chk("dwell_short_held", int'(sel), 1);
        tick();
        chk("dwell_short_end", int'(sel), 2);
        abort();
`endif

        ticks(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
